store_align_unit: RTL and testbench
===================================

// Module: store_align_unit
// PURPOSE
//  Parametrised store-path aligner between the execute stage and the data memory.
//  Accepts one store request (address, size, raw register data) per cycle over a valid/ready handshake.
//  Emits word-aligned memory beats carrying lane-shifted write data plus per-byte enables.
//  Stores that cross a bus-word boundary are split into two beats, or faulted (see CONFIGURATION).
// PARAMETERS
//  XLEN    32  data/bus width in bits; legal values 32 or 64; NB = XLEN/8 bytes per beat
//  ADDR_W  32  byte-address width
// PORTS
//  clk          in   1       clock, rising edge
//  rst_n        in   1       asynchronous active-low reset
//  req_valid    in   1       store request valid
//  req_ready    out  1       unit can accept a request this cycle
//  req_addr     in   ADDR_W  byte address of store
//  req_size     in   2       00 byte, 01 half, 10 word, 11 dword (dword legal only when XLEN=64)
//  req_data     in   XLEN    store data, right-justified (bit 0 = LSB of the stored value)
//  mem_valid    out  1       memory beat valid
//  mem_ready    in   1       memory accepts beat
//  mem_addr     out  ADDR_W  beat address, low log2(NB) bits always 0
//  mem_wdata    out  XLEN    lane-shifted write data; disabled lanes driven 0
//  mem_be       out  NB      byte enables; bit i qualifies mem_wdata[8i+7:8i]
//  mem_last     out  1       final beat of the current store
//  misalign_err out  1       one-cycle pulse when a misaligned store is rejected
// BEHAVIOUR
//  - Reset, asynchronous: mem_valid=0, mem_addr=0, mem_wdata=0, mem_be=0, mem_last=0, misalign_err=0; FSM=IDLE.
//  - Size decode: nbytes = 1<<req_size. A size above log2(NB) is treated as full width (NB bytes).
//  - Lane math: off = req_addr[log2(NB)-1:0].
//    - wide_data (2*XLEN) = zero-extended data masked to nbytes, shifted left by 8*off.
//    - wide_be (2*NB) = ((1<<nbytes)-1) << off.
//    - Beat 0 takes the low halves; beat 1 takes the high halves at mem_addr + NB.
//  - Handshake:
//    - req_ready = (FSM==IDLE) && (!mem_valid || mem_ready). A request is accepted when req_valid && req_ready.
//    - Beat transfer occurs when mem_valid && mem_ready.
//    - While mem_valid && !mem_ready, all mem_* outputs are held stable.
//  - Latency: request accepted at edge N -> beat 0 presented from edge N (registered, visible in cycle N+1).
//    - Throughput of aligned stores is 1 per cycle when mem_ready stays high.
//  - FSM states:
//    - IDLE: on accept, if the high half of wide_be is zero, load beat 0 with mem_last=1 and stay in IDLE.
//      Otherwise load beat 0 with mem_last=0, latch the high halves, and go to SPLIT.
//    - SPLIT: on beat-0 transfer, load beat 1 with mem_last=1 and go to DRAIN.
//    - DRAIN: on beat-1 transfer, clear mem_valid unless a new request is accepted the same edge
//      (req_ready is low in DRAIN, so no new request is accepted), then return to IDLE.
//  - A misaligned store that fits inside one bus word (e.g. half at off=1) is a single beat when split is enabled.
//  - Reset mid-operation: any pending beat or latched second half is discarded, and no beat follows reset release.
// CONFIGURATION
//  - Macro STORE_MISALIGN_SPLIT_EN.
//  - Defined: behaviour as above; crossing stores are split into two beats; misalign_err is tied to 0.
//  - Undefined: any store with (off % nbytes) != 0 is rejected.
//    - No mem beat is issued; misalign_err pulses high for exactly one cycle, the cycle after accept.
//    - req_ready follows the normal rule; the SPLIT and DRAIN states and the second-half registers are not built.
// STRUCTURE
//  - Package store_pkg: size enum (SZ_B, SZ_H, SZ_W, SZ_D), FSM state enum (IDLE, SPLIT, DRAIN),
//    and a function to compute nbytes from size and NB.
//  - Sub-module store_lane_shift (combinational, parametrised XLEN): size/offset -> wide_data, wide_be.
//    Instantiated once.
// TESTING (XLEN=32)
//  1. SB addr 0x1003 data 0x000000AB -> mem_addr 0x1000, wdata 0xAB000000, be 1000, last 1, one beat.
//  2. SH addr 0x2002 data 0xFFFF1234 -> mem_addr 0x2000, wdata 0x12340000, be 1100, last 1.
//  3. SW addr 0x3001 data 0xDDCCBBAA, split enabled:
//     - beat 0: addr 0x3000, wdata 0xCCBBAA00, be 1110, last 0.
//     - beat 1: addr 0x3004, wdata 0x000000DD, be 0001, last 1.
//     - req_ready=0 until beat 1 transfers.
//     - Split disabled: no beat, misalign_err high for 1 cycle.
//  4. Backpressure: beat presented with mem_ready=0 for 3 cycles -> mem_* constant, req_ready=0;
//     beat transfers in cycle 4.
//  5. Reset mid-split: rst_n low after beat-0 transfer -> mem_valid=0 immediately,
//     no beat 1 after release, req_ready=1.
//  6. Eight back-to-back aligned SW with mem_ready=1 -> eight beats in eight consecutive cycles, data/addr in order.

Source files
------------

// File: rtl/store_pkg.sv
// rtl/store_pkg.sv - shared size/state types and size decode for the store aligner
package store_pkg;

  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2, SZ_D = 2'd3} size_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SPLIT = 2'd1, DRAIN = 2'd2} state_e;

  // Sizes wider than the bus collapse to a full-width store.
  function automatic int unsigned size_nbytes(input logic [1:0] size, input int unsigned nb);
    int unsigned n;
    n = 32'd1 << size;
    return (n > nb) ? nb : n;
  endfunction

endpackage

// File: rtl/store_lane_shift.sv
// rtl/store_lane_shift.sv - masks store data to its size and shifts data/enables into byte lanes
module store_lane_shift #(
  parameter int XLEN = 32,
  parameter int NB   = XLEN / 8,
  parameter int OW   = $clog2(NB)
) (
  input  logic [1:0]        size,
  input  logic [OW-1:0]     off,
  input  logic [XLEN-1:0]   data,
  output logic [2*XLEN-1:0] wide_data,
  output logic [2*NB-1:0]   wide_be
);
  import store_pkg::*;

  logic [XLEN-1:0] masked;
  logic [NB-1:0]   be_base;
  int unsigned     nbytes;

  always_comb begin
    masked  = '0;
    be_base = '0;
    nbytes  = size_nbytes(size, NB);
    for (int unsigned i = 0; i < NB; i++) begin
      if (i < nbytes) begin
        masked[8*i +: 8] = data[8*i +: 8];
        be_base[i]       = 1'b1;
      end
    end
    wide_data = {{XLEN{1'b0}}, masked} << {off, 3'b000};
    wide_be   = {{NB{1'b0}}, be_base} << off;
  end

endmodule

// File: rtl/store_align_unit.sv
// rtl/store_align_unit.sv - store-path aligner producing word-aligned memory beats
// STORE_MISALIGN_SPLIT_EN: split bus-crossing stores into two beats instead of faulting them.
module store_align_unit #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [XLEN-1:0]   req_data,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  output logic              mem_last,
  output logic              misalign_err
);
  import store_pkg::*;

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  logic [OW-1:0]     off;
  logic [2*XLEN-1:0] wide_data;
  logic [2*NB-1:0]   wide_be;
  logic [ADDR_W-1:0] base_addr;
  logic              accept;
  logic              xfer;

  state_e            state_q, state_d;
  logic              valid_d, last_d;
  logic [ADDR_W-1:0] addr_d;
  logic [XLEN-1:0]   wdata_d;
  logic [NB-1:0]     be_d;

  assign off       = req_addr[OW-1:0];
  assign base_addr = {req_addr[ADDR_W-1:OW], {OW{1'b0}}};
  assign req_ready = (state_q == IDLE) && (!mem_valid || mem_ready);
  assign accept    = req_valid && req_ready;
  assign xfer      = mem_valid && mem_ready;

  store_lane_shift #(.XLEN(XLEN)) u_lane_shift (
    .size      (req_size),
    .off       (off),
    .data      (req_data),
    .wide_data (wide_data),
    .wide_be   (wide_be)
  );

`ifdef STORE_MISALIGN_SPLIT_EN
  logic [XLEN-1:0] hi_data_q, hi_data_d;
  logic [NB-1:0]   hi_be_q, hi_be_d;

  assign misalign_err = 1'b0;
`else
  logic            err_q, err_d;
  logic [OW-1:0]   nb_mask;
  logic            misaligned;
  logic            unused_hi;

  // Only aligned stores get through, so the upper lane half is never needed.
  assign unused_hi    = ^{wide_data[2*XLEN-1:XLEN], wide_be[2*NB-1:NB]};
  assign nb_mask      = OW'(size_nbytes(req_size, NB) - 1);
  assign misaligned   = |(off & nb_mask);
  assign misalign_err = err_q;
`endif

  always_comb begin
    state_d = state_q;
    valid_d = mem_valid;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    be_d    = mem_be;
    last_d  = mem_last;
`ifdef STORE_MISALIGN_SPLIT_EN
    hi_data_d = hi_data_q;
    hi_be_d   = hi_be_q;
`else
    err_d = 1'b0;
`endif
    if (xfer) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef STORE_MISALIGN_SPLIT_EN
          valid_d = 1'b1;
          addr_d  = base_addr;
          wdata_d = wide_data[XLEN-1:0];
          be_d    = wide_be[NB-1:0];
          last_d  = ~|wide_be[2*NB-1:NB];
          if (|wide_be[2*NB-1:NB]) begin
            hi_data_d = wide_data[2*XLEN-1:XLEN];
            hi_be_d   = wide_be[2*NB-1:NB];
            state_d   = SPLIT;
          end
`else
          if (misaligned) begin
            err_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            addr_d  = base_addr;
            wdata_d = wide_data[XLEN-1:0];
            be_d    = wide_be[NB-1:0];
            last_d  = 1'b1;
          end
`endif
        end
      end
`ifdef STORE_MISALIGN_SPLIT_EN
      SPLIT: begin
        if (xfer) begin
          valid_d = 1'b1;
          addr_d  = mem_addr + ADDR_W'(NB);
          wdata_d = hi_data_q;
          be_d    = hi_be_q;
          last_d  = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      mem_last  <= 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
      hi_data_q <= '0;
      hi_be_q   <= '0;
`else
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mem_valid <= valid_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_be    <= be_d;
      mem_last  <= last_d;
`ifdef STORE_MISALIGN_SPLIT_EN
      hi_data_q <= hi_data_d;
      hi_be_q   <= hi_be_d;
`else
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_store_align_unit.sv
// tb/tb_store_align_unit.sv - byte-level reference model plus directed store vectors for store_align_unit
module tb_store_align_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_last;
  logic        misalign_err;

  store_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_data     (req_data),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_last     (mem_last),
    .misalign_err (misalign_err)
  );

`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  int    log_cyc[$];
  int    err_pend = 0;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    held = 0;
  beat_t hold_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Place each stored byte at its absolute address, then group bytes by bus word.
  function automatic void model_push(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int          off, nb, pos, nbeats;
    logic [31:0] wd [2];
    logic [3:0]  be [2];
    off = int'(a % 4);
    nb  = ((1 << s) > 4) ? 4 : (1 << s);
    wd[0] = '0; wd[1] = '0; be[0] = '0; be[1] = '0;
    if (!SPLIT_EN && (off % nb) != 0) begin
      err_pend++;
    end else begin
      for (int k = 0; k < nb; k++) begin
        pos = off + k;
        wd[pos / 4][8*(pos % 4) +: 8] = d[8*k +: 8];
        be[pos / 4][pos % 4] = 1'b1;
      end
      nbeats = (off + nb > 4) ? 2 : 1;
      for (int b = 0; b < nbeats; b++)
        exp_q.push_back('{(a & 32'hFFFF_FFFC) + 32'(4 * b), wd[b], be[b], (b == nbeats - 1)});
    end
  endfunction

  always @(negedge clk) begin
    beat_t e;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      err_pend = 0;
      held = 0;
    end else begin
      if (held)
        chk("hold_stable", {mem_valid, mem_addr, mem_wdata, mem_be, mem_last},
            {1'b1, hold_b.addr, hold_b.wdata, hold_b.be, hold_b.last});
      if (misalign_err) begin
        chk("err_expected", (err_pend > 0), 1);
        if (err_pend > 0) err_pend--;
      end
      if (mem_valid && mem_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("beat_addr", mem_addr, e.addr);
          chk("beat_wdata", mem_wdata, e.wdata);
          chk("beat_be", mem_be, e.be);
          chk("beat_last", mem_last, e.last);
        end
        log_q.push_back('{mem_addr, mem_wdata, mem_be, mem_last});
        log_cyc.push_back(cyc);
      end
      held = mem_valid && !mem_ready;
      hold_b = '{mem_addr, mem_wdata, mem_be, mem_last};
    end
  end

  task automatic send(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    bit done;
    done = 0;
    req_valid = 1'b1; req_addr = a; req_size = s; req_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        model_push(a, s, d);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    req_valid = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && err_pend == 0) ok = 1;
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_log(input string name, input int idx, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be, input logic last);
    if (idx >= log_q.size()) begin
      chk({name, "_present"}, 0, 1);
    end else begin
      chk({name, "_addr"}, log_q[idx].addr, a);
      chk({name, "_wdata"}, log_q[idx].wdata, wd);
      chk({name, "_be"}, log_q[idx].be, be);
      chk({name, "_last"}, log_q[idx].last, last);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_size = '0; req_data = '0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_mem_last", mem_last, 0);
    chk("rst_misalign_err", misalign_err, 0);
    chk("rst_req_ready", req_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte store into the top lane.
    n0 = log_q.size();
    send(32'h1003, 2'd0, 32'h0000_00AB);
    drain();
    chk("t1_beats", log_q.size() - n0, 1);
    chk_log("t1", n0, 32'h1000, 32'hAB00_0000, 4'b1000, 1'b1);

    // Half store in the upper half-word, upper data bits discarded.
    n0 = log_q.size();
    send(32'h2002, 2'd1, 32'hFFFF_1234);
    drain();
    chk_log("t2", n0, 32'h2000, 32'h1234_0000, 4'b1100, 1'b1);

    // Word store crossing the bus word.
    n0 = log_q.size();
    send(32'h3001, 2'd2, 32'hDDCC_BBAA);
    req_valid = 1'b0;
`ifdef STORE_MISALIGN_SPLIT_EN
    @(negedge clk);
    chk("t3_ready_beat0", req_ready, 0);
    chk("t3_last_beat0", mem_last, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_ready_beat1", req_ready, 0);
    chk("t3_valid_beat1", mem_valid, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_ready_after", req_ready, 1);
    drain();
    chk_log("t3_b0", n0, 32'h3000, 32'hCCBB_AA00, 4'b1110, 1'b0);
    chk_log("t3_b1", n0 + 1, 32'h3004, 32'h0000_00DD, 4'b0001, 1'b1);
`else
    @(negedge clk);
    chk("t3_err_pulse", misalign_err, 1);
    chk("t3_no_beat", mem_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_err_cleared", misalign_err, 0);
    drain();
    chk("t3_beats", log_q.size() - n0, 0);
`endif

    // Assorted lanes and sizes, checked through the model.
    for (int i = 0; i < 4; i++) send(32'h4000 + 32'(i), 2'd0, 32'h0000_0050 + 32'(i));
    send(32'h4100, 2'd1, 32'h0000_BEEF);
    send(32'h5004, 2'd2, 32'h0102_0304);
    send(32'h6000, 2'd3, 32'h1122_3344);
    send(32'h7003, 2'd1, 32'h0000_2211);
    n0 = log_q.size();
    send(32'h7001, 2'd1, 32'h0000_BBAA);
    drain();
`ifdef STORE_MISALIGN_SPLIT_EN
    chk_log("t_inword", n0, 32'h7000, 32'h00BB_AA00, 4'b0110, 1'b1);
`else
    chk("t_inword_beats", log_q.size() - n0, 0);
`endif

    // Backpressure: three stalled cycles, transfer in the fourth.
    mem_ready = 1'b0;
    n0 = log_q.size();
    send(32'h8000, 2'd2, 32'h5566_7788);
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_ready_low", req_ready, 0);
      chk("t4_valid_high", mem_valid, 1);
      @(posedge clk); #1;
    end
    chk("t4_no_early_xfer", log_q.size() - n0, 0);
    mem_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_on_xfer", req_ready, 1);
    @(posedge clk); #1;
    chk("t4_beats", log_q.size() - n0, 1);
    chk_log("t4", n0, 32'h8000, 32'h5566_7788, 4'b1111, 1'b1);
    drain();

`ifdef STORE_MISALIGN_SPLIT_EN
    // Reset after beat 0 has transferred discards beat 1.
    n0 = log_q.size();
    send(32'h3001, 2'd2, 32'hDDCC_BBAA);
    req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5_valid_in_reset", mem_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_beat1", mem_valid, 0);
      chk("t5_ready", req_ready, 1);
    end
    chk("t5_beats", log_q.size() - n0, 1);
    @(posedge clk); #1;
`endif

    // Reset with a stalled beat pending drops the beat.
    mem_ready = 1'b0;
    n0 = log_q.size();
    send(32'hA000, 2'd2, 32'h1234_5678);
    req_valid = 1'b0;
    @(negedge clk);
    chk("t5b_pending", mem_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t5b_valid_in_reset", mem_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5b_no_beat", mem_valid, 0);
    end
    chk("t5b_beats", log_q.size() - n0, 0);
    @(posedge clk); #1;

    // Eight back-to-back aligned words at full throughput.
    n0 = log_q.size();
    for (int i = 0; i < 8; i++) send(32'h9000 + 32'(4 * i), 2'd2, 32'hC0DE_0000 + 32'(i));
    drain();
    chk("t6_beats", log_q.size() - n0, 8);
    if (log_q.size() - n0 == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("t6_cycle", log_cyc[n0 + i] - log_cyc[n0], i);
        chk("t6_addr", log_q[n0 + i].addr, 32'h9000 + 32'(4 * i));
        chk("t6_data", log_q[n0 + i].wdata, 32'hC0DE_0000 + 32'(i));
      end
    end

    drain();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_err_pending", err_pend, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
